// File: rtl/atm_keypad_entry.sv
// ATM keypad front-end: assembles decimal key entries into session credentials and requests.
// Optional inactivity timeout is compiled in when KEYPAD_TIMEOUT_EN is defined.
module atm_keypad_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  input  logic        req_ready,
  output logic [11:0] acc_number,
  output logic [3:0]  pin,
  output logic        session_active,
  output logic        req_valid,
  output logic [2:0]  menu_option,
  output logic [11:0] dest_acc_number,
  output logic [10:0] amount,
  output logic        exit,
  output logic        entry_error
);

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE, S_ACC, S_PIN, S_MENU, S_DEST, S_AMOUNT, S_ISSUE
  } state_t;

  state_t      state;
  logic [13:0] acc;
  logic [2:0]  digits;
  logic [13:0] acc_next;
  logic [13:0] field_max;
  logic [2:0]  field_len;
  logic        key_acc;
  logic        is_digit;
  logic        digit_ok;
  logic        timeout_hit;
  logic        end_session;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    field_max = '0;
    field_len = '0;
    case (state)
      S_ACC, S_DEST: begin field_max = 14'd4095; field_len = 3'd4; end
      S_PIN:         begin field_max = 14'd15;   field_len = 3'd2; end
      S_MENU:        begin field_max = 14'd7;    field_len = 3'd1; end
      S_AMOUNT:      begin field_max = 14'd2047; field_len = 3'd4; end
      default:       ;
    endcase
  end

  assign key_acc  = key_valid && key_ready;
  assign is_digit = (key_code <= 4'd9);
  // The digit-count limit keeps acc below 1000 here, so 14 bits never wrap.
  assign acc_next = acc * 14'd10 + {10'd0, key_code};
  assign digit_ok = (digits < field_len) && (acc_next <= field_max);

`ifdef KEYPAD_TIMEOUT_EN
  logic [19:0] idle_cnt;
  assign timeout_hit = (state != S_IDLE) && (state != S_ISSUE) && !key_acc &&
                       (idle_cnt == 20'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // CANCEL in MENU and inactivity both tear the session down the same way.
  assign end_session = timeout_hit ||
                       (key_acc && (state == S_MENU) && (key_code == KEY_CANCEL));

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      acc             <= '0;
      digits          <= '0;
      key_ready       <= 1'b0;
      acc_number      <= '0;
      pin             <= '0;
      session_active  <= 1'b0;
      req_valid       <= 1'b0;
      menu_option     <= '0;
      dest_acc_number <= '0;
      amount          <= '0;
      exit            <= 1'b0;
      entry_error     <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
      idle_cnt        <= '0;
`endif
    end else begin
      exit        <= 1'b0;
      entry_error <= 1'b0;
      key_ready   <= 1'b1;
`ifdef KEYPAD_TIMEOUT_EN
      if (key_acc || timeout_hit || state == S_IDLE || state == S_ISSUE)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 20'd1;
`endif
      if (end_session) begin
        exit           <= 1'b1;
        session_active <= 1'b0;
        acc_number     <= '0;
        pin            <= '0;
        state          <= S_IDLE;
        acc            <= '0;
        digits         <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (key_acc && is_digit) begin
              acc    <= {10'd0, key_code};
              digits <= 3'd1;
              state  <= S_ACC;
            end
          end
          S_ISSUE: begin
            key_ready <= req_ready;
            if (req_ready) begin
              req_valid <= 1'b0;
              state     <= S_MENU;
            end
          end
          default: begin
            if (key_acc) begin
              if (is_digit) begin
                if (digit_ok) begin
                  acc    <= acc_next;
                  digits <= digits + 3'd1;
                end else begin
                  entry_error <= 1'b1;
                end
              end else begin
                case (key_code)
                  KEY_ENTER: begin
                    if (digits == 3'd0) begin
                      entry_error <= 1'b1;
                    end else begin
                      case (state)
                        S_ACC: begin
                          acc_number <= acc[11:0];
                          state      <= S_PIN;
                          acc        <= '0;
                          digits     <= '0;
                        end
                        S_PIN: begin
                          pin            <= acc[3:0];
                          session_active <= 1'b1;
                          state          <= S_MENU;
                          acc            <= '0;
                          digits         <= '0;
                        end
                        S_MENU: begin
                          case (acc[2:0])
                            3'd3: begin
                              menu_option     <= 3'd3;
                              amount          <= '0;
                              dest_acc_number <= '0;
                              req_valid       <= 1'b1;
                              key_ready       <= 1'b0;
                              state           <= S_ISSUE;
                              acc             <= '0;
                              digits          <= '0;
                            end
                            3'd4, 3'd5, 3'd7: begin
                              menu_option     <= acc[2:0];
                              dest_acc_number <= '0;
                              state           <= S_AMOUNT;
                              acc             <= '0;
                              digits          <= '0;
                            end
                            3'd6: begin
                              menu_option <= 3'd6;
                              state       <= S_DEST;
                              acc         <= '0;
                              digits      <= '0;
                            end
                            default: entry_error <= 1'b1;
                          endcase
                        end
                        S_DEST: begin
                          dest_acc_number <= acc[11:0];
                          state           <= S_AMOUNT;
                          acc             <= '0;
                          digits          <= '0;
                        end
                        S_AMOUNT: begin
                          amount    <= acc[10:0];
                          req_valid <= 1'b1;
                          key_ready <= 1'b0;
                          state     <= S_ISSUE;
                          acc       <= '0;
                          digits    <= '0;
                        end
                        default: ;
                      endcase
                    end
                  end
                  KEY_CLEAR: begin
                    acc    <= '0;
                    digits <= '0;
                  end
                  KEY_CANCEL: begin
                    acc    <= '0;
                    digits <= '0;
                    // Before PIN entry no session exists, so the account is simply dropped.
                    if (state == S_ACC || state == S_PIN) begin
                      acc_number <= '0;
                      state      <= S_IDLE;
                    end else begin
                      state <= S_MENU;
                    end
                  end
                  default: entry_error <= 1'b1;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Self-checking bench for atm_keypad_entry: directed test-plan scenarios plus random keys
// compared against a digit-list reference model.
module tb_atm_keypad_entry;

  localparam int ENT = 10, CLR = 11, CAN = 12;
`ifdef KEYPAD_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        req_ready = 1'b0;
  logic        key_ready;
  logic [11:0] acc_number;
  logic [3:0]  pin;
  logic        session_active;
  logic        req_valid;
  logic [2:0]  menu_option;
  logic [11:0] dest_acc_number;
  logic [10:0] amount;
  logic        exit;
  logic        entry_error;

  atm_keypad_entry #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .req_ready(req_ready), .acc_number(acc_number), .pin(pin),
    .session_active(session_active), .req_valid(req_valid), .menu_option(menu_option),
    .dest_acc_number(dest_acc_number), .amount(amount), .exit(exit), .entry_error(entry_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: field = 0 idle,1 acc,2 pin,3 menu,4 dest,5 amount,6 issue
  int mf;
  int digs[$];
  int fmax[7] = '{0, 4095, 15, 7, 4095, 2047, 0};
  int flen[7] = '{0, 4, 2, 1, 4, 4, 0};
  int e_accn, e_pin, e_sess, e_rv, e_opt, e_dest, e_amt, e_err, e_exit;

  function int fval();
    int v;
    v = 0;
    foreach (digs[i]) v = v * 10 + digs[i];
    return v;
  endfunction

  function void model_reset();
    mf = 0; digs.delete();
    e_accn = 0; e_pin = 0; e_sess = 0; e_rv = 0; e_opt = 0; e_dest = 0; e_amt = 0;
    e_err = 0; e_exit = 0;
  endfunction

  function void model_end_session();
    e_exit = 1; e_sess = 0; e_accn = 0; e_pin = 0; mf = 0; digs.delete();
  endfunction

  function void model_key(int k);
    int v;
    e_err = 0; e_exit = 0;
    if (mf == 6) return;
    if (mf == 0) begin
      if (k <= 9) begin digs.delete(); digs.push_back(k); mf = 1; end
      return;
    end
    if (k <= 9) begin
      if (digs.size() < flen[mf] && fval() * 10 + k <= fmax[mf]) digs.push_back(k);
      else e_err = 1;
    end else if (k == ENT) begin
      if (digs.size() == 0) begin
        e_err = 1;
      end else begin
        v = fval();
        case (mf)
          1: begin e_accn = v; mf = 2; digs.delete(); end
          2: begin e_pin = v; e_sess = 1; mf = 3; digs.delete(); end
          3: begin
            if (v == 3) begin e_opt = 3; e_amt = 0; e_dest = 0; e_rv = 1; mf = 6; digs.delete(); end
            else if (v == 4 || v == 5 || v == 7) begin e_opt = v; e_dest = 0; mf = 5; digs.delete(); end
            else if (v == 6) begin e_opt = 6; mf = 4; digs.delete(); end
            else e_err = 1;
          end
          4: begin e_dest = v; mf = 5; digs.delete(); end
          5: begin e_amt = v; e_rv = 1; mf = 6; digs.delete(); end
          default: ;
        endcase
      end
    end else if (k == CLR) begin
      digs.delete();
    end else if (k == CAN) begin
      if (mf == 1 || mf == 2) begin mf = 0; e_accn = 0; digs.delete(); end
      else if (mf == 3) model_end_session();
      else begin mf = 3; digs.delete(); end
    end else begin
      e_err = 1;
    end
  endfunction

  function void model_handshake();
    e_rv = 0; mf = 3; digs.delete(); e_err = 0; e_exit = 0;
  endfunction

  // Drives one key for one cycle and compares all outputs right after the edge.
  task press(input string nm, input int k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(k);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    model_key(k);
    checks++;
    if ({entry_error, exit, session_active, req_valid, key_ready} !==
        {e_err[0], e_exit[0], e_sess[0], e_rv[0], (mf != 6)}) begin
      failures++;
      $display("FAIL %s key=%0d err/exit/sess/rv/kr got=%b%b%b%b%b exp=%0d%0d%0d%0d%0d", nm, k,
               entry_error, exit, session_active, req_valid, key_ready,
               e_err, e_exit, e_sess, e_rv, (mf != 6));
    end
    checks++;
    if (acc_number !== 12'(e_accn) || pin !== 4'(e_pin)) begin
      failures++;
      $display("FAIL %s key=%0d acc_number/pin got=%0d/%0d exp=%0d/%0d", nm, k,
               acc_number, pin, e_accn, e_pin);
    end
    if (e_rv != 0) begin
      checks++;
      if (menu_option !== 3'(e_opt) || dest_acc_number !== 12'(e_dest) || amount !== 11'(e_amt)) begin
        failures++;
        $display("FAIL %s key=%0d opt/dest/amt got=%0d/%0d/%0d exp=%0d/%0d/%0d", nm, k,
                 menu_option, dest_acc_number, amount, e_opt, e_dest, e_amt);
      end
    end
  endtask

  // Keys as hex characters, e.g. "2178A4A".
  task press_str(input string nm, input string s);
    int k;
    for (int i = 0; i < s.len(); i++) begin
      k = (int'(s[i]) <= 57) ? int'(s[i]) - 48 : int'(s[i]) - 55;
      press(nm, k);
    end
  endtask

  task handshake(input string nm, input int wait_n);
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      req_ready = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (req_valid !== 1'b1 || key_ready !== 1'b0 || amount !== 11'(e_amt) ||
          menu_option !== 3'(e_opt)) begin
        failures++;
        $display("FAIL %s hold cycle %0d rv/kr/opt/amt got=%b/%b/%0d/%0d exp=1/0/%0d/%0d", nm, i,
                 req_valid, key_ready, menu_option, amount, e_opt, e_amt);
      end
    end
    @(negedge clk);
    req_ready = 1'b1;
    @(posedge clk);
    #1;
    req_ready = 1'b0;
    model_handshake();
    checks++;
    if (req_valid !== 1'b0 || key_ready !== 1'b1 || entry_error !== 1'b0) begin
      failures++;
      $display("FAIL %s after handshake rv/kr/err got=%b/%b/%b exp=0/1/0", nm,
               req_valid, key_ready, entry_error);
    end
  endtask

  task apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task test_reset();
    #12;
    checks++;
    if ({key_ready, acc_number, pin, session_active, req_valid, menu_option, dest_acc_number,
         amount, exit, entry_error} !== '0) begin
      failures++;
      $display("FAIL reset outputs not zero: kr=%b acc=%0d pin=%0d sess=%b rv=%b", key_ready,
               acc_number, pin, session_active, req_valid);
    end
    apply_reset();
    checks++;
    if (key_ready !== 1'b1 || session_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_release kr/sess got=%b/%b exp=1/0", key_ready, session_active);
    end
  endtask

  task test_login();
    press_str("login", "2178A4A");
    checks++;
    if (acc_number !== 12'd2178 || pin !== 4'd4 || session_active !== 1'b1 || req_valid !== 1'b0) begin
      failures++;
      $display("FAIL login acc/pin/sess/rv got=%0d/%0d/%b/%b exp=2178/4/1/0", acc_number, pin,
               session_active, req_valid);
    end
  endtask

  task test_withdraw();
    press_str("withdraw", "5A100A");
    checks++;
    if (req_valid !== 1'b1 || menu_option !== 3'd5 || amount !== 11'd100) begin
      failures++;
      $display("FAIL withdraw rv/opt/amt got=%b/%0d/%0d exp=1/5/100", req_valid, menu_option, amount);
    end
    handshake("withdraw", 3);
  endtask

  task test_transfer();
    press_str("transfer", "6A2816A50A");
    checks++;
    if (menu_option !== 3'd6 || dest_acc_number !== 12'd2816 || amount !== 11'd50) begin
      failures++;
      $display("FAIL transfer opt/dest/amt got=%0d/%0d/%0d exp=6/2816/50", menu_option,
               dest_acc_number, amount);
    end
    handshake("transfer", 0);
  endtask

  task test_limits();
    press_str("amt_limit", "4A2550A");
    checks++;
    if (amount !== 11'd255) begin
      failures++;
      $display("FAIL amt_limit amount got=%0d exp=255", amount);
    end
    handshake("amt_limit", 1);
    press_str("menu_bad", "1AB");
    press_str("menu_cancel", "C");
    press_str("acc_limit", "4096A");
    checks++;
    if (acc_number !== 12'd409) begin
      failures++;
      $display("FAIL acc_limit acc_number got=%0d exp=409", acc_number);
    end
    press_str("pin_limit", "16B9A");
  endtask

  task test_cancel_clear();
    press_str("clear", "7A3B7A");
    checks++;
    if (amount !== 11'd7) begin
      failures++;
      $display("FAIL clear amount got=%0d exp=7", amount);
    end
    handshake("clear", 2);
    press_str("empty_enter", "A");
    press_str("illegal", "E");
    press_str("amt_cancel", "5AC");
    press_str("menu_cancel", "C");
    checks++;
    if (acc_number !== 12'd0 || session_active !== 1'b0) begin
      failures++;
      $display("FAIL menu_cancel acc/sess got=%0d/%b exp=0/0", acc_number, session_active);
    end
    press_str("idle_ignore", "FAB");
    press_str("acc_cancel", "12C");
    press_str("relogin", "2178A4A");
  endtask

  task test_issue_drop();
    req_ready = 1'b0;
    press_str("issue_drop", "3A5");
    handshake("issue_drop", 1);
  endtask

  task test_back_to_back();
    req_ready = 1'b1;
    press_str("b2b", "3A");
    @(posedge clk);
    #1;
    model_handshake();
    req_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b0 || key_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b early handshake rv/kr got=%b/%b exp=0/1", req_valid, key_ready);
    end
    press_str("b2b", "3A");
    handshake("b2b", 0);
  endtask

  task test_async_reset();
    press_str("async_rst", "3A");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_ready, acc_number, pin, session_active, req_valid, menu_option, dest_acc_number,
         amount, exit, entry_error} !== '0) begin
      failures++;
      $display("FAIL async_rst outputs not zero: kr=%b acc=%0d sess=%b rv=%b opt=%0d", key_ready,
               acc_number, session_active, req_valid, menu_option);
    end
    apply_reset();
    press_str("relogin", "2178A4A");
  endtask

  task test_timeout();
    bit exp_exit;
    press_str("timeout", "3A");
    handshake("timeout", 0);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      exp_exit = TMO && (i == 16);
      checks++;
      if (exit !== exp_exit) begin
        failures++;
        $display("FAIL timeout exit at cycle %0d got=%b exp=%b", i, exit, exp_exit);
      end
    end
    if (TMO) begin
      model_end_session();
      e_exit = 0;
    end
    checks++;
    if (session_active !== e_sess[0]) begin
      failures++;
      $display("FAIL timeout session_active got=%b exp=%0d", session_active, e_sess);
    end
    press_str("after_timeout", "3A");
  endtask

  task test_random();
    int k;
    int r;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      if (mf == 6) begin
        handshake("random", int'($urandom_range(0, 3)));
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 65)      k = int'($urandom_range(0, 9));
        else if (r < 85) k = ENT;
        else if (r < 90) k = CLR;
        else if (r < 93) k = CAN;
        else             k = int'($urandom_range(13, 15));
        press("random", k);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_login();
    test_withdraw();
    test_transfer();
    test_limits();
    test_cancel_clear();
    test_issue_drop();
    test_back_to_back();
    test_async_reset();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atm_keypad_entry.md
# atm_keypad_entry

Keypad front-end that sits directly upstream of the ATM controller. It collects single-key codes from the keypad scanner and assembles them into decimal fields: account number, PIN, menu option, destination account and amount. It then presents the session credentials as held levels and each transaction as a valid/ready request. It also generates the controller's `exit` pulse on cancel or inactivity.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: inactivity limit in clk cycles (used only with the timeout macro).
- `clk  in  1`  system clock, rising edge.
- `rst_n  in  1`  asynchronous, active-low reset.
- `key_valid  in  1`  key strobe, one cycle per keypress.
- `key_code  in  4`  key code:
  - 0–9: digit
  - 0xA: ENTER
  - 0xB: CLEAR
  - 0xC: CANCEL
  - 0xD–0xF: illegal
- `key_ready  out  1`  high when a key can be accepted (low in ISSUE).
- `req_ready  in  1`  controller accepts the current request.
- `acc_number  out  12`  session account number, held while the session is active.
- `pin  out  4`  session PIN, held.
- `session_active  out  1`  credentials are valid.
- `req_valid  out  1`  transaction request pending.
- `menu_option  out  3`  request opcode.
- `dest_acc_number  out  12`  destination account; meaningful only for option 6.
- `amount  out  11`  request amount; 0 for option 3.
- `exit  out  1`  one-cycle pulse that ends the session.
- `entry_error  out  1`  one-cycle pulse flagging a rejected key.

## Operation
- States: IDLE, ACC, PIN, MENU, DEST, AMOUNT, ISSUE.
- Reset: all outputs 0; state IDLE; accumulator 0; digit count 0.
- **IDLE**: the first digit key loads the accumulator and moves to ACC. Non-digit keys are ignored silently.
- **Digit entry**: `acc = acc*10 + d`, computed at 14 bits.
  - A digit is rejected (entry_error pulse, accumulator unchanged) if the result exceeds the field maximum or the digit count is already at the field limit.
  - Field limits: ACC ≤4095, 4 digits. PIN ≤15, 2 digits. MENU ≤7, 1 digit. DEST ≤4095, 4 digits. AMOUNT ≤2047, 4 digits.
- **ENTER with zero digits**: entry_error pulse; state unchanged.
- **ENTER with ≥1 digit**:
  - ACC → PIN: latch `acc_number`.
  - PIN → MENU: latch `pin`; set `session_active`.
  - MENU, value 3 → ISSUE with amount 0.
  - MENU, value 4, 5 or 7 → AMOUNT.
  - MENU, value 6 → DEST.
  - MENU, value 0–2 → entry_error pulse; stay in MENU.
  - DEST → AMOUNT: latch `dest_acc_number`.
  - AMOUNT → ISSUE: latch `amount`.
- **On any state change**: clear the accumulator and digit count.
- **CLEAR**: zeroes the accumulator and digit count of the current field; state unchanged.
- **CANCEL**:
  - In ACC/PIN: go to IDLE; no exit pulse (no session exists).
  - In DEST/AMOUNT: return to MENU, discarding the partial request.
  - In MENU: `exit` pulse, clear `session_active`, `acc_number` and `pin`; go to IDLE.
- **Illegal codes 0xD–0xF**: entry_error pulse outside IDLE.
- **ISSUE**:
  - Enter ISSUE with `req_valid`=1; `menu_option`, `dest_acc_number` and `amount` are stable until the handshake.
  - Handshake completes on `req_valid && req_ready` at a rising edge. Next cycle `req_valid`=0 and state is MENU.
  - `key_ready`=0 in ISSUE; keys arriving in ISSUE are dropped.

## Timing
- One key processed per cycle. All outputs are registered.
- Output update latency is 1 cycle after the key edge:
  - ENTER in AMOUNT → `req_valid` high on the next cycle.
  - ENTER in PIN → `session_active` high on the next cycle.
- `req_ready` may already be high when `req_valid` rises. The minimum ISSUE residency is 1 cycle, so there is no back-to-back request without a MENU pass.
- `exit` and `entry_error` are exactly one cycle wide.
- `key_valid` with `key_ready`=0 is ignored; the key is not queued.
- Reset asserted mid-session or mid-ISSUE: all outputs drop immediately (asynchronously) to their reset values.

## Configuration
- `KEYPAD_TIMEOUT_EN` defined:
  - A 20-bit inactivity counter runs in ACC, PIN, MENU, DEST and AMOUNT. Any accepted key resets it.
  - At count `TIMEOUT_CYCLES-1`, behave as CANCEL from MENU (exit pulse, session cleared, IDLE) regardless of the current state. The exit pulse fires even from ACC/PIN.
  - The counter is held at 0 in IDLE and ISSUE.
- Not defined: no counter exists; the block waits indefinitely.

## Test plan
- Login: keys 2,1,7,8,ENTER,4,ENTER → `acc_number`=2178, `pin`=4, `session_active`=1; no `req_valid`.
- Withdraw-and-show: from MENU, keys 5,ENTER,1,0,0,ENTER with `req_ready` low 3 cycles then high → `req_valid` held 3 cycles then handshake with `menu_option`=5, `amount`=100; then MENU.
- Transfer: keys 6,ENTER,2,8,1,6,ENTER,5,0,ENTER → request `menu_option`=6, `dest_acc_number`=2816, `amount`=50.
- Limits: amount keys 2,5,5 then 0 → the 0 gives entry_error and amount stays 255. ACC keys 4,0,9,6 → the 6 is rejected and `acc_number` becomes 409 after ENTER. Menu 1,ENTER → entry_error, stays in MENU.
- Cancel/clear: in AMOUNT, CLEAR then 7,ENTER → `amount`=7. In MENU, CANCEL → one-cycle `exit`, `acc_number`=0, `session_active`=0.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): idle in MENU for 16 cycles → `exit` pulse, IDLE. With the macro off, the same stimulus leaves the block in MENU.
